// File: rtl/game_pkg.sv
// Shared types and preset tables for the game setup controller and its countdown timer.
package game_pkg;

    typedef enum logic [1:0] {
        EASY   = 2'd0,
        MEDIUM = 2'd1,
        HARD   = 2'd2,
        CUSTOM = 2'd3
    } level_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_READY,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } setup_state_t;

    localparam int unsigned FIELD_SIZE_DEF = 64;

    // Indexed by level_t; the CUSTOM slot is unused and never selected.
    localparam logic [3:0][4:0] PRESET_ROWS  = {5'd0, 5'd15, 5'd10, 5'd8};
    localparam logic [3:0][7:0] PRESET_MINES = {8'd0, 8'd40, 8'd30, 8'd19};
    localparam logic [3:0][7:0] PRESET_SECS  = {8'd0, 8'd70, 8'd50, 8'd45};

endpackage

// File: rtl/game_sec_timer.sv
// Seconds countdown: prescaler plus 8-bit down counter with load, pause and expiry detect.
// Bonus-time adder is built only when GAME_SETUP_BONUS_TIME_EN is defined.
module game_sec_timer #(
    parameter int unsigned CLK_FREQ_HZ   = 65_000_000,
    parameter int unsigned BONUS_SECONDS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       clr_pre,
    input  logic       cnt_en,
    input  logic       bonus_en,
    output logic [7:0] secs,
    output logic       expire
);

    localparam int unsigned PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ_HZ - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [7:0]    secs_nxt;

`ifdef GAME_SETUP_BONUS_TIME_EN
    logic [8:0] sum;

    always_comb begin
        tick     = cnt_en && (pre == PRE_TC);
        sum      = {1'b0, secs} + 9'(BONUS_SECONDS) - {8'd0, tick};
        secs_nxt = secs;
        if (bonus_en)
            secs_nxt = sum[8] ? 8'hFF : sum[7:0];
        else if (tick && secs != '0)
            secs_nxt = secs - 8'd1;
        // A bonus landing on the final tick keeps the game alive.
        expire = tick && (secs == 8'd1) && !bonus_en;
    end
`else
    logic unused_bonus;
    assign unused_bonus = bonus_en ^ BONUS_SECONDS[0];

    always_comb begin
        tick     = cnt_en && (pre == PRE_TC);
        secs_nxt = secs;
        if (tick && secs != '0)
            secs_nxt = secs - 8'd1;
        expire = tick && (secs == 8'd1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            secs <= '0;
        end else begin
            if (load || clr_pre)
                pre <= '0;
            else if (cnt_en)
                pre <= tick ? '0 : pre + 1'b1;

            if (load)
                secs <= load_val;
            else
                secs <= secs_nxt;
        end
    end

endmodule

// File: rtl/game_setup_ctrl.sv
// Game configuration handshake, board geometry and countdown control.
// Optional bonus time is enabled by defining GAME_SETUP_BONUS_TIME_EN.
module game_setup_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 65_000_000,
    parameter int unsigned FIELD_SIZE    = FIELD_SIZE_DEF,
    parameter int unsigned X_CENTER      = 512,
    parameter int unsigned Y_CENTER      = 384,
    parameter int unsigned MAX_ROWS      = 16,
    parameter int unsigned BONUS_SECONDS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  level_sel,
    input  logic [4:0]  cust_rows,
    input  logic [7:0]  cust_mines,
    input  logic [7:0]  cust_seconds,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        bonus,
    output logic [4:0]  rows,
    output logic [7:0]  mines,
    output logic [10:0] board_size,
    output logic [10:0] board_xpos,
    output logic [10:0] board_ypos,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  seconds_left,
    output logic        timer_running,
    output logic        time_up
);

    setup_state_t state, nxt;

    level_t      lvl_q;
    logic [4:0]  c_rows_q;
    logic [7:0]  c_mines_q, c_secs_q;
    logic        have_cfg;
    logic [7:0]  cfg_secs;

    logic [4:0]  sel_rows;
    logic [7:0]  sel_mines, sel_secs;
    logic        sel_ok;
    logic [9:0]  sq;
    logic [10:0] bsz_c, half_c, xpos_c, ypos_c;

    logic        accept, active, t_load, t_clr, t_cnt, t_bonus, t_expire, tu_nxt;
    logic [7:0]  t_val;

    always_comb begin
        sq = {5'd0, c_rows_q} * {5'd0, c_rows_q};
        if (lvl_q == CUSTOM) begin
            sel_rows  = c_rows_q;
            sel_mines = c_mines_q;
            sel_secs  = c_secs_q;
            sel_ok    = (c_rows_q >= 5'd2) && (32'(c_rows_q) <= MAX_ROWS) &&
                        (c_mines_q != '0) && ({2'b00, c_mines_q} < sq);
        end else begin
            sel_rows  = PRESET_ROWS[lvl_q];
            sel_mines = PRESET_MINES[lvl_q];
            sel_secs  = PRESET_SECS[lvl_q];
            sel_ok    = 1'b1;
        end
        bsz_c  = 11'(FIELD_SIZE) * {6'd0, sel_rows};
        half_c = bsz_c >> 1;
        // Boards wider than the screen centre are pinned to the left/top edge.
        xpos_c = ({1'b0, half_c} > 12'(X_CENTER)) ? '0 : 11'(12'(X_CENTER) - {1'b0, half_c});
        ypos_c = ({1'b0, half_c} > 12'(Y_CENTER)) ? '0 : 11'(12'(Y_CENTER) - {1'b0, half_c});
    end

    assign active        = (state == S_RUN) || (state == S_PAUSED);
    assign t_cnt         = active && !stop && !pause;
    assign t_bonus       = active && !stop && bonus;
    assign timer_running = (state == S_RUN);

    always_comb begin
        nxt       = state;
        t_load    = 1'b0;
        t_val     = cfg_secs;
        t_clr     = 1'b0;
        tu_nxt    = 1'b0;
        cfg_ready = (state == S_IDLE) || (state == S_READY) || (state == S_EXPIRED);
        accept    = cfg_valid && cfg_ready;
        case (state)
            S_IDLE: if (accept) nxt = S_CALC;
            S_CALC: begin
                if (sel_ok) begin
                    nxt    = S_READY;
                    t_load = 1'b1;
                    t_val  = sel_secs;
                end else begin
                    nxt = have_cfg ? S_READY : S_IDLE;
                end
            end
            S_READY: begin
                if (accept) nxt = S_CALC;
                else if (start) begin
                    if (seconds_left == '0) begin
                        nxt    = S_EXPIRED;
                        tu_nxt = 1'b1;
                    end else begin
                        nxt   = S_RUN;
                        t_clr = 1'b1;
                    end
                end
            end
            S_RUN, S_PAUSED: begin
                if (stop) begin
                    nxt    = S_READY;
                    t_load = 1'b1;
                end else if (t_expire) begin
                    nxt    = S_EXPIRED;
                    tu_nxt = 1'b1;
                end else begin
                    nxt = pause ? S_PAUSED : S_RUN;
                end
            end
            S_EXPIRED: begin
                if (accept) nxt = S_CALC;
                else if (start) begin
                    t_load = 1'b1;
                    if (cfg_secs == '0) tu_nxt = 1'b1;
                    else                nxt    = S_RUN;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q      <= EASY;
            c_rows_q   <= '0;
            c_mines_q  <= '0;
            c_secs_q   <= '0;
            have_cfg   <= 1'b0;
            cfg_secs   <= '0;
            rows       <= '0;
            mines      <= '0;
            board_size <= '0;
            board_xpos <= '0;
            board_ypos <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            time_up    <= 1'b0;
        end else begin
            cfg_done <= (state == S_CALC);
            time_up  <= tu_nxt;
            if (accept) begin
                lvl_q     <= level_t'(level_sel);
                c_rows_q  <= cust_rows;
                c_mines_q <= cust_mines;
                c_secs_q  <= cust_seconds;
                cfg_err   <= 1'b0;
            end
            if (state == S_CALC) begin
                if (sel_ok) begin
                    rows       <= sel_rows;
                    mines      <= sel_mines;
                    board_size <= bsz_c;
                    board_xpos <= xpos_c;
                    board_ypos <= ypos_c;
                    cfg_secs   <= sel_secs;
                    have_cfg   <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    game_sec_timer #(
        .CLK_FREQ_HZ   (CLK_FREQ_HZ),
        .BONUS_SECONDS (BONUS_SECONDS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .clr_pre  (t_clr),
        .cnt_en   (t_cnt),
        .bonus_en (t_bonus),
        .secs     (seconds_left),
        .expire   (t_expire)
    );

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Self-checking bench for game_setup_ctrl: config table, timing sequences and a randomized model run.
module tb_game_setup_ctrl;

    localparam int CLK = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [1:0]  level_sel = '0;
    logic [4:0]  cust_rows = '0;
    logic [7:0]  cust_mines = '0, cust_seconds = '0;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, bonus = 1'b0;
    logic [4:0]  rows;
    logic [7:0]  mines;
    logic [10:0] board_size, board_xpos, board_ypos;
    logic        cfg_done, cfg_err, timer_running, time_up;
    logic [7:0]  seconds_left;

    game_setup_ctrl #(.CLK_FREQ_HZ(CLK)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .level_sel(level_sel), .cust_rows(cust_rows), .cust_mines(cust_mines),
        .cust_seconds(cust_seconds), .start(start), .pause(pause), .stop(stop),
        .bonus(bonus), .rows(rows), .mines(mines), .board_size(board_size),
        .board_xpos(board_xpos), .board_ypos(board_ypos), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .seconds_left(seconds_left), .timer_running(timer_running),
        .time_up(time_up)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cycle_no = 0, start_cyc = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic rdy, done, err, run, tu,
                                         input logic [7:0] s, input logic [4:0] r,
                                         input logic [7:0] m, input logic [10:0] b, x, y);
        return {5'd0, rdy, done, err, run, tu, s, r, m, b, x, y};
    endfunction

    function automatic logic [63:0] dut_vec();
        return pack(cfg_ready, cfg_done, cfg_err, timer_running, time_up, seconds_left,
                    rows, mines, board_size, board_xpos, board_ypos);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        start_cyc = cycle_no;
    endtask

    task automatic do_cfg(input logic [1:0] l, input logic [4:0] r, input logic [7:0] m, s);
        @(negedge clk);
        level_sel = l; cust_rows = r; cust_mines = m; cust_seconds = s; cfg_valid = 1'b1;
        @(posedge clk); #1; cfg_valid = 1'b0;
        chk("calc_ready_low", cfg_ready, 0);
        chk("cfg_done_early", cfg_done, 0);
        cyc(1);
        chk("cfg_done_pulse", cfg_done, 1);
        cyc(1);
        chk("cfg_done_clear", cfg_done, 0);
    endtask

    task automatic wait_tu(output int d);
        d = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (time_up) begin
                d = cycle_no - start_cyc;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] lvl; logic [4:0] r; logic [7:0] m, s;
        logic err; logic [4:0] er; logic [7:0] em; logic [10:0] eb, ex, ey; logic [7:0] es;
    } cfg_vec_t;
    cfg_vec_t tbl [10];

    // Reference model state (post-edge values)
    localparam int M_IDLE = 0, M_CALC = 1, M_READY = 2, M_RUN = 3, M_PAUSED = 4, M_EXP = 5;
    int m_mode, m_frac, m_secs, m_cfg_secs, m_rows, m_mines, m_bsz, m_x, m_y;
    int c_lvl, c_r, c_m, c_s;
    bit m_have, m_err, m_done, m_tu;

    task model_reset();
        m_mode = M_IDLE; m_frac = 0; m_secs = 0; m_cfg_secs = 0; m_rows = 0; m_mines = 0;
        m_bsz = 0; m_x = 0; m_y = 0; m_have = 0; m_err = 0; m_done = 0; m_tu = 0;
        c_lvl = 0; c_r = 0; c_m = 0; c_s = 0;
    endtask

    task model_step();
        int r, m, s, ns;
        bit ok, t;
        m_done = 0; m_tu = 0;
        case (m_mode)
            M_CALC: begin
                case (c_lvl)
                    0: begin r = 8;  m = 19; s = 45; ok = 1; end
                    1: begin r = 10; m = 30; s = 50; ok = 1; end
                    2: begin r = 15; m = 40; s = 70; ok = 1; end
                    default: begin
                        r = c_r; m = c_m; s = c_s;
                        ok = (r >= 2) && (r <= 16) && (m >= 1) && (m < r * r);
                    end
                endcase
                m_done = 1;
                if (ok) begin
                    m_rows = r; m_mines = m; m_bsz = r * 64;
                    m_x = 512 - m_bsz / 2; if (m_x < 0) m_x = 0;
                    m_y = 384 - m_bsz / 2; if (m_y < 0) m_y = 0;
                    m_cfg_secs = s; m_secs = s; m_have = 1; m_mode = M_READY;
                end else begin
                    m_err = 1;
                    m_mode = m_have ? M_READY : M_IDLE;
                end
            end
            M_RUN, M_PAUSED: begin
                if (stop) begin
                    m_mode = M_READY; m_secs = m_cfg_secs;
                end else begin
                    t = !pause && (m_frac == CLK - 1);
                    if (!pause) m_frac = (m_frac + 1) % CLK;
                    ns = m_secs - int'(t);
`ifdef GAME_SETUP_BONUS_TIME_EN
                    if (bonus) begin
                        ns = m_secs + 5 - int'(t);
                        if (ns > 255) ns = 255;
                    end
`endif
                    m_secs = ns;
                    if (t && ns == 0) begin m_tu = 1; m_mode = M_EXP; end
                    else m_mode = pause ? M_PAUSED : M_RUN;
                end
            end
            default: begin
                if (cfg_valid) begin
                    c_lvl = level_sel; c_r = cust_rows; c_m = cust_mines; c_s = cust_seconds;
                    m_err = 0; m_mode = M_CALC;
                end else if (start && m_mode == M_READY) begin
                    if (m_secs == 0) begin m_mode = M_EXP; m_tu = 1; end
                    else begin m_mode = M_RUN; m_frac = 0; end
                end else if (start && m_mode == M_EXP) begin
                    m_secs = m_cfg_secs; m_frac = 0;
                    if (m_secs == 0) m_tu = 1; else m_mode = M_RUN;
                end
            end
        endcase
    endtask

    function automatic logic [63:0] model_vec();
        bit rdy;
        rdy = (m_mode == M_IDLE) || (m_mode == M_READY) || (m_mode == M_EXP);
        return pack(rdy, m_done, m_err, m_mode == M_RUN, m_tu, 8'(m_secs), 5'(m_rows),
                    8'(m_mines), 11'(m_bsz), 11'(m_x), 11'(m_y));
    endfunction

    logic [63:0] reset_vec;
    int d;

    initial begin
        tbl[0] = '{2'd0, 5'd0,  8'd0,   8'd0,   1'b0, 5'd8,  8'd19,  11'd512,  11'd256, 11'd128, 8'd45};
        tbl[1] = '{2'd2, 5'd31, 8'd0,   8'd0,   1'b0, 5'd15, 8'd40,  11'd960,  11'd32,  11'd0,   8'd70};
        tbl[2] = '{2'd1, 5'd0,  8'd0,   8'd0,   1'b0, 5'd10, 8'd30,  11'd640,  11'd192, 11'd64,  8'd50};
        tbl[3] = '{2'd3, 5'd16, 8'd0,   8'd9,   1'b1, 5'd10, 8'd30,  11'd640,  11'd192, 11'd64,  8'd50};
        tbl[4] = '{2'd3, 5'd4,  8'd15,  8'd3,   1'b0, 5'd4,  8'd15,  11'd256,  11'd384, 11'd256, 8'd3};
        tbl[5] = '{2'd3, 5'd1,  8'd0,   8'd7,   1'b1, 5'd4,  8'd15,  11'd256,  11'd384, 11'd256, 8'd3};
        tbl[6] = '{2'd3, 5'd17, 8'd20,  8'd7,   1'b1, 5'd4,  8'd15,  11'd256,  11'd384, 11'd256, 8'd3};
        tbl[7] = '{2'd3, 5'd4,  8'd16,  8'd7,   1'b1, 5'd4,  8'd15,  11'd256,  11'd384, 11'd256, 8'd3};
        tbl[8] = '{2'd3, 5'd16, 8'd255, 8'd200, 1'b0, 5'd16, 8'd255, 11'd1024, 11'd0,   11'd0,   8'd200};
        tbl[9] = '{2'd3, 5'd2,  8'd3,   8'd0,   1'b0, 5'd2,  8'd3,   11'd128,  11'd448, 11'd320, 8'd0};

        reset_vec = pack(1, 0, 0, 0, 0, 8'd0, 5'd0, 8'd0, 11'd0, 11'd0, 11'd0);

        cyc(2);
        chk("reset_in", dut_vec(), reset_vec);
        @(negedge clk); rst_n = 1'b1;
        cyc(2);
        chk("reset_idle", dut_vec(), reset_vec);

        // Illegal custom from reset falls back to IDLE; start/stop ignored there
        do_cfg(2'd3, 5'd16, 8'd0, 8'd9);
        chk("first_err", cfg_err, 1);
        chk("first_err_ready", cfg_ready, 1);
        chk("first_err_rows", rows, 0);
        pulse_start();
        chk("idle_start_ignored", timer_running, 0);
        chk("idle_start_ready", cfg_ready, 1);

        foreach (tbl[i]) begin
            do_cfg(tbl[i].lvl, tbl[i].r, tbl[i].m, tbl[i].s);
            chk($sformatf("tbl%0d", i), dut_vec(),
                pack(1, 0, tbl[i].err, 0, 0, tbl[i].es, tbl[i].er, tbl[i].em,
                     tbl[i].eb, tbl[i].ex, tbl[i].ey));
        end

        // Start with zero seconds expires at once
        pulse_start();
        chk("zero_start_tu", time_up, 1);
        chk("zero_start_run", timer_running, 0);
        chk("zero_start_ready", cfg_ready, 1);
        cyc(1);
        chk("zero_start_tu_clr", time_up, 0);

        // Plain countdown from 3 seconds
        do_cfg(2'd3, 5'd4, 8'd15, 8'd3);
        pulse_start();
        chk("run_start", {timer_running, cfg_ready, seconds_left}, {1'b1, 1'b0, 8'd3});
        cyc(9);  chk("cd_pre1", seconds_left, 3);
        cyc(1);  chk("cd_sec2", seconds_left, 2);
        cyc(10); chk("cd_sec1", seconds_left, 1);
        cyc(9);  chk("cd_pre0", {time_up, seconds_left}, {1'b0, 8'd1});
        cyc(1);  chk("cd_expire", {time_up, seconds_left, timer_running, cfg_ready},
                     {1'b1, 8'd0, 1'b0, 1'b1});
        cyc(1);  chk("cd_tu_once", {time_up, seconds_left}, {1'b0, 8'd0});

        // 25 paused cycles delay expiry by 25
        pulse_start();
        chk("restart_reload", seconds_left, 3);
        cyc(5);
        @(negedge clk); pause = 1'b1;
        cyc(1);
        chk("paused_state", {timer_running, cfg_ready}, 2'b00);
        repeat (24) @(posedge clk);
        @(negedge clk); pause = 1'b0;
        chk("paused_frozen", seconds_left, 3);
        wait_tu(d);
        chk("pause_delay", d, 55);

        // Stop together with pause returns to READY with seconds reloaded
        pulse_start();
        cyc(14);
        chk("pre_stop_secs", seconds_left, 2);
        @(negedge clk); stop = 1'b1; pause = 1'b1;
        @(posedge clk); #1; stop = 1'b0; pause = 1'b0;
        chk("stop_state", {timer_running, cfg_ready, seconds_left}, {1'b0, 1'b1, 8'd3});
        cyc(12);
        chk("ready_holds", {time_up, seconds_left}, {1'b0, 8'd3});

        // Bonus time
        do_cfg(2'd3, 5'd4, 8'd1, 8'd253);
        pulse_start();
        @(negedge clk); bonus = 1'b1;
        @(posedge clk); #1; bonus = 1'b0;
`ifdef GAME_SETUP_BONUS_TIME_EN
        chk("bonus_sat", seconds_left, 255);
`else
        chk("bonus_ignored", seconds_left, 253);
`endif
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        chk("bonus_stop_reload", seconds_left, 253);

        // Asynchronous reset mid-run
        pulse_start();
        cyc(3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_vec(), reset_vec);
        @(negedge clk); rst_n = 1'b1;
        model_reset();

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cfg_valid    = ($urandom_range(0, 14) == 0);
            level_sel    = 2'($urandom_range(0, 3));
            cust_rows    = 5'($urandom_range(0, 18));
            cust_mines   = 8'($urandom_range(0, 30));
            cust_seconds = 8'($urandom_range(0, 4));
            start        = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            bonus        = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            @(posedge clk);
            model_step();
            #1;
            chk("rand_cycle", dut_vec(), model_vec());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
